native_port_traffic_gen: RTL



---
 rtl/native_port_traffic_gen.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/native_port_traffic_gen.sv
// Strided write / read / write-then-verify traffic engine for the LiteDRAM native user port.
// Define TRAFFIC_GEN_VERIFY_EN to compile in the read-data comparator and error registers.
module native_port_traffic_gen #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   stride,
  input  logic [CNT_W-1:0]    count,
  input  logic [31:0]         seed,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_we,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic                wdata_valid,
  input  logic                wdata_ready,
  output logic [DATA_W/8-1:0] wdata_we,
  output logic [DATA_W-1:0]   wdata_data,
  input  logic                rdata_valid,
  output logic                rdata_ready,
  input  logic [DATA_W-1:0]   rdata_data,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam int LANES = DATA_W / 32;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_CMD, S_RD_DATA, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                rd_after_q, rd_after_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         seed_q, seed_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                cmd_we_q, cmd_we_d;
  logic                wdata_valid_q, wdata_valid_d;
  logic [DATA_W-1:0]   wdata_data_q, wdata_data_d;
  logic                rdata_ready_q, rdata_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cmd_seen_q, cmd_seen_d;
  logic                wd_seen_q, wd_seen_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [ADDR_W-1:0]   first_err_q, first_err_d;
  logic                err_seen_q, err_seen_d;

  logic                cmd_hs, wd_hs, rd_hs, cmd_got, wd_got, last_txn;
  logic [ADDR_W-1:0]   next_addr;

  function automatic logic [DATA_W-1:0] pattern(input logic [31:0] sd, input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    logic [31:0]       a32;
    p   = '0;
    a32 = 32'(a);
    for (int k = 0; k < LANES; k++) p[32*k +: 32] = sd + a32 + 32'(k);
    return p;
  endfunction

  assign cmd_hs    = cmd_valid_q & cmd_ready;
  assign wd_hs     = wdata_valid_q & wdata_ready;
  assign rd_hs     = rdata_ready_q & rdata_valid;
  assign cmd_got   = cmd_seen_q | cmd_hs;
  assign wd_got    = wd_seen_q | wd_hs;
  assign last_txn  = (remain_q == CNT_W'(1));
  assign next_addr = addr_q + stride_q;

  always_comb begin
    state_d       = state_q;
    rd_after_d    = rd_after_q;
    base_d        = base_q;
    stride_d      = stride_q;
    count_d       = count_q;
    seed_d        = seed_q;
    remain_d      = remain_q;
    addr_d        = addr_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_we_d      = cmd_we_q;
    wdata_valid_d = wdata_valid_q;
    wdata_data_d  = wdata_data_q;
    rdata_ready_d = rdata_ready_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    cmd_seen_d    = cmd_seen_q;
    wd_seen_d     = wd_seen_q;
    err_count_d   = err_count_q;
    first_err_d   = first_err_q;
    err_seen_d    = err_seen_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_after_d  = mode[1];
          base_d      = base_addr;
          stride_d    = stride;
          count_d     = count;
          seed_d      = seed;
          remain_d    = count;
          addr_d      = base_addr;
          busy_d      = 1'b1;
          err_count_d = '0;
          first_err_d = '0;
          err_seen_d  = 1'b0;
          cmd_seen_d  = 1'b0;
          wd_seen_d   = 1'b0;
          if (count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (mode == 2'd1) begin
            state_d     = S_RD_CMD;
            cmd_valid_d = 1'b1;
            cmd_we_d    = 1'b0;
          end else begin
            state_d       = S_WR;
            cmd_valid_d   = 1'b1;
            cmd_we_d      = 1'b1;
            wdata_valid_d = 1'b1;
            wdata_data_d  = pattern(seed, base_addr);
          end
        end
      end

      S_WR: begin
        if (cmd_got && wd_got) begin
          cmd_seen_d = 1'b0;
          wd_seen_d  = 1'b0;
          if (!last_txn) begin
            // Back-to-back: both valids stay up with the next address and pattern.
            remain_d      = remain_q - CNT_W'(1);
            addr_d        = next_addr;
            cmd_valid_d   = 1'b1;
            wdata_valid_d = 1'b1;
            wdata_data_d  = pattern(seed_q, next_addr);
          end else if (rd_after_q) begin
            state_d       = S_RD_CMD;
            remain_d      = count_q;
            addr_d        = base_q;
            cmd_valid_d   = 1'b1;
            cmd_we_d      = 1'b0;
            wdata_valid_d = 1'b0;
          end else begin
            state_d       = S_DONE;
            done_d        = 1'b1;
            cmd_valid_d   = 1'b0;
            cmd_we_d      = 1'b0;
            wdata_valid_d = 1'b0;
          end
        end else begin
          cmd_seen_d    = cmd_got;
          wd_seen_d     = wd_got;
          cmd_valid_d   = ~cmd_got;
          wdata_valid_d = ~wd_got;
        end
      end

      S_RD_CMD: begin
        if (cmd_hs) begin
          state_d       = S_RD_DATA;
          cmd_valid_d   = 1'b0;
          rdata_ready_d = 1'b1;
        end
      end

      S_RD_DATA: begin
        if (rd_hs) begin
          rdata_ready_d = 1'b0;
`ifdef TRAFFIC_GEN_VERIFY_EN
          if (rdata_data != pattern(seed_q, addr_q)) begin
            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
            if (!err_seen_q) begin
              first_err_d = addr_q;
              err_seen_d  = 1'b1;
            end
          end
`endif
          if (last_txn) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = S_RD_CMD;
            remain_d    = remain_q - CNT_W'(1);
            addr_d      = next_addr;
            cmd_valid_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q       <= S_IDLE;
      rd_after_q    <= 1'b0;
      base_q        <= '0;
      stride_q      <= '0;
      count_q       <= '0;
      seed_q        <= '0;
      remain_q      <= '0;
      addr_q        <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_we_q      <= 1'b0;
      wdata_valid_q <= 1'b0;
      wdata_data_q  <= '0;
      rdata_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cmd_seen_q    <= 1'b0;
      wd_seen_q     <= 1'b0;
      err_count_q   <= '0;
      first_err_q   <= '0;
      err_seen_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_after_q    <= rd_after_d;
      base_q        <= base_d;
      stride_q      <= stride_d;
      count_q       <= count_d;
      seed_q        <= seed_d;
      remain_q      <= remain_d;
      addr_q        <= addr_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_we_q      <= cmd_we_d;
      wdata_valid_q <= wdata_valid_d;
      wdata_data_q  <= wdata_data_d;
      rdata_ready_q <= rdata_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cmd_seen_q    <= cmd_seen_d;
      wd_seen_q     <= wd_seen_d;
      err_count_q   <= err_count_d;
      first_err_q   <= first_err_d;
      err_seen_q    <= err_seen_d;
    end
  end

`ifndef TRAFFIC_GEN_VERIFY_EN
  // Read data is accepted and dropped when the comparator is not built.
  logic unused_rdata;
  assign unused_rdata = ^rdata_data;
`endif

  assign cmd_valid      = cmd_valid_q;
  assign cmd_we         = cmd_we_q;
  assign cmd_addr       = addr_q;
  assign wdata_valid    = wdata_valid_q;
  assign wdata_we       = '1;
  assign wdata_data     = wdata_data_q;
  assign rdata_ready    = rdata_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;

endmodule
